id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter DW, default 16, datapath width of every operand field.
REQ-002 SHALL have parameter SW, default 8, width of ALU source-select codes.
REQ-003 SHALL have parameter ZERO_SEL, default 8'b00010000, source-select code meaning "constant zero", used for bubbles.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous and active-low.
REQ-006 stall  input  1  hold all outputs for this cycle.
REQ-007 flush  input  1  replace the captured instruction with a bubble.
REQ-008 in_valid  input  1  decode stage presents a real instruction.
REQ-009 in_data_rx, in_data_ry, in_imm3, in_imm8, in_data_IN, in_data_SP, in_data_T, in_data_pc  input  DW each  decoded operands.
REQ-010 in_ALU_Src1, in_ALU_Src2  input  SW each  ALU operand-select codes.
REQ-011 in_ALU_Op  input  4  ALU operation code.
REQ-012 in_reg_write, in_mem_read, in_mem_write  input  1 each  downstream control.
REQ-013 in_wb_addr  input  4  write-back register index.
REQ-014 Outputs: every in_* field has a registered out_* counterpart of the same width; plus out_valid 1 and out_sel_err 1.

Function
REQ-015 Latency SHALL be exactly one cycle: a field presented at edge N appears on out_* after edge N.
REQ-016 Priority per edge SHALL be: reset, then flush, then stall, then load.
REQ-017 Load (no flush, no stall): all out_* take in_*; out_valid takes in_valid.
REQ-018 Stall (no flush): all outputs including out_valid and out_sel_err SHALL keep prior values.
REQ-019 Flush (stall ignored): bubble loaded -- all data outputs 0, out_ALU_Src1 = out_ALU_Src2 = ZERO_SEL, out_ALU_Op 0, out_reg_write/mem_read/mem_write 0, out_wb_addr 0, out_valid 0, out_sel_err 0.
REQ-020 Load with in_valid = 0 SHALL load a bubble identical to REQ-019.
REQ-021 Legal select codes SHALL be 8'b00000101, 8'b00010000, 8'b00010001, 8'b00010010, 8'b00001000, 8'b00001001, 8'b00001010, 8'b00010011.
REQ-022 Load with in_valid = 1 and an illegal in_ALU_Src1 or in_ALU_Src2 SHALL replace each illegal code with ZERO_SEL, force out_reg_write, out_mem_read, out_mem_write to 0, and set out_sel_err 1 for that instruction only.
REQ-023 Load with in_valid = 1 and both codes legal SHALL set out_sel_err 0.
REQ-024 out_mem_read and out_mem_write both 1 on a valid load SHALL be passed unchanged; no arbitration here.
REQ-025 No combinational path SHALL exist from any input to any output.
REQ-026 Stall held for any number of cycles SHALL keep outputs stable; the first non-stall edge applies REQ-016 normally.

Reset
REQ-027 rst = 0 at an edge SHALL load the bubble of REQ-019, regardless of stall, flush or in_valid.
REQ-028 Reset asserted between edges SHALL have no effect until the next rising edge.
REQ-029 Reset mid-stall SHALL discard the held instruction; after release outputs follow REQ-016 from the first edge.

Verification
REQ-030 Reset: rst=0 one edge with in_valid=1, stall=1 -> out_valid 0, out_ALU_Src1 8'h10, all data 0, out_sel_err 0.
REQ-031 Load: in_valid=1, in_data_rx 16'h1234, in_ALU_Src1 8'h05, in_reg_write 1 -> next edge out_data_rx 16'h1234, out_ALU_Src1 8'h05, out_reg_write 1, out_valid 1.
REQ-032 Stall: after REQ-031, stall=1 for 3 edges with in_data_rx 16'hFFFF -> out_data_rx stays 16'h1234 for all 3; stall=0 -> 16'hFFFF.
REQ-033 Flush beats stall: stall=1, flush=1 with valid instruction held -> out_valid 0, out_mem_write 0, out_ALU_Src2 8'h10.
REQ-034 Illegal select: in_valid=1, in_ALU_Src1 8'h07, in_mem_write 1 -> out_ALU_Src1 8'h10, out_mem_write 0, out_sel_err 1, out_valid 1; next legal load -> out_sel_err 0.
REQ-035 Back-to-back: three valid loads with in_data_pc 16'h0001, 16'h0002, 16'h0003 on consecutive edges -> out_data_pc follows one cycle later, no drop or repeat.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: one-cycle capture of decoded operands and control,
// with stall hold, flush/invalid bubbles and ALU source-select sanitising.
module id_ex_reg #(
  parameter int            DW       = 16,
  parameter int            SW       = 8,
  parameter logic [SW-1:0] ZERO_SEL = SW'(8'b00010000)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data_rx,
  input  logic [DW-1:0] in_data_ry,
  input  logic [DW-1:0] in_imm3,
  input  logic [DW-1:0] in_imm8,
  input  logic [DW-1:0] in_data_IN,
  input  logic [DW-1:0] in_data_SP,
  input  logic [DW-1:0] in_data_T,
  input  logic [DW-1:0] in_data_pc,
  input  logic [SW-1:0] in_ALU_Src1,
  input  logic [SW-1:0] in_ALU_Src2,
  input  logic [3:0]    in_ALU_Op,
  input  logic          in_reg_write,
  input  logic          in_mem_read,
  input  logic          in_mem_write,
  input  logic [3:0]    in_wb_addr,
  output logic [DW-1:0] out_data_rx,
  output logic [DW-1:0] out_data_ry,
  output logic [DW-1:0] out_imm3,
  output logic [DW-1:0] out_imm8,
  output logic [DW-1:0] out_data_IN,
  output logic [DW-1:0] out_data_SP,
  output logic [DW-1:0] out_data_T,
  output logic [DW-1:0] out_data_pc,
  output logic [SW-1:0] out_ALU_Src1,
  output logic [SW-1:0] out_ALU_Src2,
  output logic [3:0]    out_ALU_Op,
  output logic          out_reg_write,
  output logic          out_mem_read,
  output logic          out_mem_write,
  output logic [3:0]    out_wb_addr,
  output logic          out_valid,
  output logic          out_sel_err
);

  typedef struct packed {
    logic [DW-1:0] data_rx;
    logic [DW-1:0] data_ry;
    logic [DW-1:0] imm3;
    logic [DW-1:0] imm8;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_sp;
    logic [DW-1:0] data_t;
    logic [DW-1:0] data_pc;
    logic [SW-1:0] alu_src1;
    logic [SW-1:0] alu_src2;
    logic [3:0]    alu_op;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic [3:0]    wb_addr;
    logic          valid;
    logic          sel_err;
  } stage_t;

  function automatic logic sel_legal(input logic [SW-1:0] code);
    return code inside {SW'(8'b00000101), SW'(8'b00010000), SW'(8'b00010001),
                        SW'(8'b00010010), SW'(8'b00001000), SW'(8'b00001001),
                        SW'(8'b00001010), SW'(8'b00010011)};
  endfunction

  stage_t bubble;
  stage_t loaded;
  stage_t nxt;
  stage_t q;
  logic   src1_ok;
  logic   src2_ok;
  logic   sel_ok;

  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path can infer a latch.
    bubble          = '0;
    bubble.alu_src1 = ZERO_SEL;
    bubble.alu_src2 = ZERO_SEL;

    src1_ok = sel_legal(in_ALU_Src1);
    src2_ok = sel_legal(in_ALU_Src2);
    sel_ok  = src1_ok && src2_ok;

    loaded           = '0;
    loaded.data_rx   = in_data_rx;
    loaded.data_ry   = in_data_ry;
    loaded.imm3      = in_imm3;
    loaded.imm8      = in_imm8;
    loaded.data_in   = in_data_IN;
    loaded.data_sp   = in_data_SP;
    loaded.data_t    = in_data_T;
    loaded.data_pc   = in_data_pc;
    // An illegal select is neutralised to the zero source and the instruction
    // is stripped of side effects, but still flows on so the error is visible.
    loaded.alu_src1  = src1_ok ? in_ALU_Src1 : ZERO_SEL;
    loaded.alu_src2  = src2_ok ? in_ALU_Src2 : ZERO_SEL;
    loaded.alu_op    = in_ALU_Op;
    loaded.reg_write = in_reg_write && sel_ok;
    loaded.mem_read  = in_mem_read  && sel_ok;
    loaded.mem_write = in_mem_write && sel_ok;
    loaded.wb_addr   = in_wb_addr;
    loaded.valid     = 1'b1;
    loaded.sel_err   = !sel_ok;

    nxt = in_valid ? loaded : bubble;
  end

  // Priority: reset, flush, stall, load.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!rst)        q <= bubble;
    else if (flush)  q <= bubble;
    else if (!stall) q <= nxt;
  end

  assign out_data_rx   = q.data_rx;
  assign out_data_ry   = q.data_ry;
  assign out_imm3      = q.imm3;
  assign out_imm8      = q.imm8;
  assign out_data_IN   = q.data_in;
  assign out_data_SP   = q.data_sp;
  assign out_data_T    = q.data_t;
  assign out_data_pc   = q.data_pc;
  assign out_ALU_Src1  = q.alu_src1;
  assign out_ALU_Src2  = q.alu_src2;
  assign out_ALU_Op    = q.alu_op;
  assign out_reg_write = q.reg_write;
  assign out_mem_read  = q.mem_read;
  assign out_mem_write = q.mem_write;
  assign out_wb_addr   = q.wb_addr;
  assign out_valid     = q.valid;
  assign out_sel_err   = q.sel_err;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios plus random traffic
// compared against a rule-level model of the stage register.
module tb_id_ex_reg;

  typedef struct packed {
    logic [15:0] rx, ry, imm3, imm8, d_in, sp, t, pc;
    logic [7:0]  src1, src2;
    logic [3:0]  op;
    logic        rw, mr, mw;
    logic [3:0]  wb;
    logic        valid, sel_err;
  } bundle_t;

  typedef struct {
    logic        rst, stall, flush, valid;
    logic [15:0] rx, ry, imm3, imm8, d_in, sp, t, pc;
    logic [7:0]  src1, src2;
    logic [3:0]  op;
    logic        rw, mr, mw;
    logic [3:0]  wb;
  } stim_t;

  logic    clk = 1'b0;
  stim_t   s;
  bundle_t obs;
  bundle_t exp_q = '0;
  int      total = 0;
  int      bad = 0;

  logic [15:0] o_rx, o_ry, o_imm3, o_imm8, o_in, o_sp, o_t, o_pc;
  logic [7:0]  o_src1, o_src2;
  logic [3:0]  o_op, o_wb;
  logic        o_rw, o_mr, o_mw, o_valid, o_sel_err;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .rst(s.rst), .stall(s.stall), .flush(s.flush), .in_valid(s.valid),
    .in_data_rx(s.rx), .in_data_ry(s.ry), .in_imm3(s.imm3), .in_imm8(s.imm8),
    .in_data_IN(s.d_in), .in_data_SP(s.sp), .in_data_T(s.t), .in_data_pc(s.pc),
    .in_ALU_Src1(s.src1), .in_ALU_Src2(s.src2), .in_ALU_Op(s.op),
    .in_reg_write(s.rw), .in_mem_read(s.mr), .in_mem_write(s.mw), .in_wb_addr(s.wb),
    .out_data_rx(o_rx), .out_data_ry(o_ry), .out_imm3(o_imm3), .out_imm8(o_imm8),
    .out_data_IN(o_in), .out_data_SP(o_sp), .out_data_T(o_t), .out_data_pc(o_pc),
    .out_ALU_Src1(o_src1), .out_ALU_Src2(o_src2), .out_ALU_Op(o_op),
    .out_reg_write(o_rw), .out_mem_read(o_mr), .out_mem_write(o_mw), .out_wb_addr(o_wb),
    .out_valid(o_valid), .out_sel_err(o_sel_err)
  );

  assign obs = {o_rx, o_ry, o_imm3, o_imm8, o_in, o_sp, o_t, o_pc, o_src1, o_src2,
                o_op, o_rw, o_mr, o_mw, o_wb, o_valid, o_sel_err};

  // Reference: what the stage must hold after an edge, given what it held and the inputs.
  function automatic bundle_t model(input bundle_t prev, input stim_t x);
    bundle_t b;
    bit      ok1, ok2;
    b = '0;
    b.src1 = 8'h10;
    b.src2 = 8'h10;
    if (!x.rst || x.flush) return b;
    if (x.stall) return prev;
    if (!x.valid) return b;
    ok1 = x.src1 inside {8'h05, 8'h10, 8'h11, 8'h12, 8'h08, 8'h09, 8'h0A, 8'h13};
    ok2 = x.src2 inside {8'h05, 8'h10, 8'h11, 8'h12, 8'h08, 8'h09, 8'h0A, 8'h13};
    b = '{rx: x.rx, ry: x.ry, imm3: x.imm3, imm8: x.imm8, d_in: x.d_in, sp: x.sp,
          t: x.t, pc: x.pc, src1: ok1 ? x.src1 : 8'h10, src2: ok2 ? x.src2 : 8'h10,
          op: x.op, rw: x.rw & ok1 & ok2, mr: x.mr & ok1 & ok2, mw: x.mw & ok1 & ok2,
          wb: x.wb, valid: 1'b1, sel_err: !(ok1 && ok2)};
    return b;
  endfunction

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] pick_sel();
    logic [7:0] tbl [8];
    tbl = '{8'h05, 8'h10, 8'h11, 8'h12, 8'h08, 8'h09, 8'h0A, 8'h13};
    if ($urandom_range(0, 3) != 0) return tbl[$urandom_range(0, 7)];
    return 8'($urandom);
  endfunction

  task automatic rand_fields();
    s.rx = 16'($urandom); s.ry = 16'($urandom); s.imm3 = 16'($urandom);
    s.imm8 = 16'($urandom); s.d_in = 16'($urandom); s.sp = 16'($urandom);
    s.t = 16'($urandom); s.pc = 16'($urandom);
    s.src1 = pick_sel(); s.src2 = pick_sel();
    s.op = 4'($urandom); s.wb = 4'($urandom);
    s.rw = 1'($urandom); s.mr = 1'($urandom); s.mw = 1'($urandom);
  endtask

  // One rising edge: advance the model, then compare the whole output bundle.
  task automatic step(input string tag);
    @(posedge clk);
    exp_q = model(exp_q, s);
    #1;
    check(tag, 160'(obs), 160'(exp_q));
    @(negedge clk);
  endtask

  task automatic legal_load();
    rand_fields();
    s.src1 = 8'h05; s.src2 = 8'h10;
    s.rst = 1'b1; s.stall = 1'b0; s.flush = 1'b0; s.valid = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rand_fields();
    s.rst = 1'b0; s.stall = 1'b1; s.flush = 1'b0; s.valid = 1'b1;
    step("reset");
    check("reset_valid", 160'(o_valid), 160'(0));
    check("reset_src1", 160'(o_src1), 160'(8'h10));
    check("reset_rx", 160'(o_rx), 160'(0));
    check("reset_sel_err", 160'(o_sel_err), 160'(0));

    legal_load();
    s.rx = 16'h1234; s.rw = 1'b1;
    step("load");
    check("load_rx", 160'(o_rx), 160'(16'h1234));
    check("load_src1", 160'(o_src1), 160'(8'h05));
    check("load_rw", 160'(o_rw), 160'(1));
    check("load_valid", 160'(o_valid), 160'(1));

    s.stall = 1'b1; s.rx = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      check("stall_rx", 160'(o_rx), 160'(16'h1234));
    end
    s.stall = 1'b0;
    step("unstall");
    check("unstall_rx", 160'(o_rx), 160'(16'hFFFF));

    legal_load();
    s.mw = 1'b1;
    step("pre_flush");
    s.stall = 1'b1; s.flush = 1'b1;
    step("flush_stall");
    check("flush_valid", 160'(o_valid), 160'(0));
    check("flush_mw", 160'(o_mw), 160'(0));
    check("flush_src2", 160'(o_src2), 160'(8'h10));

    legal_load();
    s.src1 = 8'h07; s.mw = 1'b1;
    step("illegal");
    check("illegal_src1", 160'(o_src1), 160'(8'h10));
    check("illegal_mw", 160'(o_mw), 160'(0));
    check("illegal_sel_err", 160'(o_sel_err), 160'(1));
    check("illegal_valid", 160'(o_valid), 160'(1));
    legal_load();
    step("legal_after");
    check("legal_sel_err", 160'(o_sel_err), 160'(0));

    for (int i = 1; i <= 3; i++) begin
      legal_load();
      s.pc = 16'(i);
      step("b2b");
      check("b2b_pc", 160'(o_pc), 160'(i));
    end

    legal_load();
    s.mr = 1'b1; s.mw = 1'b1;
    step("both_mem");
    check("both_mem", 160'({o_mr, o_mw}), 160'(2'b11));

    legal_load();
    s.valid = 1'b0;
    step("invalid_load");
    check("invalid_src1", 160'(o_src1), 160'(8'h10));

    legal_load();
    s.rx = 16'hA5A5;
    step("pre_glitch");
    s.stall = 1'b1;
    s.rst = 1'b0;
    #2;
    s.rst = 1'b1;
    step("rst_glitch");
    check("rst_glitch_rx", 160'(o_rx), 160'(16'hA5A5));

    s.rst = 1'b0;
    step("rst_mid_stall");
    check("rst_mid_stall_valid", 160'(o_valid), 160'(0));
    legal_load();
    s.rx = 16'h0BEE;
    step("after_rst");
    check("after_rst_rx", 160'(o_rx), 160'(16'h0BEE));

    for (int i = 0; i < 400; i++) begin
      rand_fields();
      s.rst   = ($urandom_range(0, 19) != 0);
      s.flush = ($urandom_range(0, 7) == 0);
      s.stall = ($urandom_range(0, 3) == 0);
      s.valid = ($urandom_range(0, 4) != 0);
      step("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
